// File: rtl/n64_deblur_est.sv
// Blur estimator and de-blur blanking controller for the N64 digital video path.
// Counts per-frame pixel-pair gradient reversals, folds each frame's verdict into a
// saturating trend with hysteresis, and drives the per-pixel blanking used for 240p de-blur.
module n64_deblur_est #(
    parameter int unsigned COLOR_W     = 7,
    parameter int unsigned CMP_BITS    = 2,
    parameter int unsigned TREND_W     = 9,
    parameter int unsigned HYST        = 8,
    parameter int unsigned EST_CNT_W   = 2,
    parameter int unsigned HOLDOFF_W   = 2,
    parameter int unsigned LOCK_FRAMES = 4
) (
    input  logic                   nCLK,
    input  logic                   nRST,
    input  logic                   nDSYNC,
    input  logic [1:0]             data_cnt,
    input  logic                   blurry_pixel_pos,
    input  logic                   n64_480i,
    input  logic                   vmode,
    input  logic [3:0]             sync_pre,
    input  logic [3*COLOR_W-1:0]   rgb_pre,
    input  logic [COLOR_W-1:0]     d_cur,
    input  logic                   force_en,
    input  logic                   force_nval,
    output logic                   ndo_deblur,
    output logic                   nblank_rgb,
    output logic                   nblur_est,
    output logic [TREND_W-1:0]     trend,
    output logic                   est_locked
);

    localparam logic [TREND_W-1:0] TrendInit  = {1'b1, {(TREND_W-1){1'b0}}};
    localparam logic [TREND_W-1:0] TrendHi    = TrendInit + TREND_W'(HYST);
    localparam logic [TREND_W-1:0] TrendLo    = TrendInit - TREND_W'(HYST);
    localparam logic [7:0]         LockFrames = 8'(LOCK_FRAMES);

    logic [2:0][1:0]       grad_q, grad_d;
    logic [2:0]            rev_q, rev_d;
    logic [EST_CNT_W-1:0]  est_cnt_q, est_cnt_d;
    logic [HOLDOFF_W-1:0]  holdoff_q, holdoff_d;
    logic [TREND_W-1:0]    trend_q, trend_d;
    logic                  nblur_q, nblur_d;
    logic                  ndo_q, ndo_d;
    logic                  nblank_q, nblank_d;
    logic                  run_est_q, run_est_d;
    logic [7:0]            frame_cnt_q, frame_cnt_d;

    logic                  sync_slot, vs_fall, hs_fall, cs_rise, eval;
    logic [COLOR_W-1:0]    pre_ch;
    logic [CMP_BITS-1:0]   pre_msb, cur_msb;
    logic [1:0]            g;

    // Only part of each channel feeds the comparators; the rest is intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{rgb_pre, d_cur};

    // Sync-word event decode and evaluation qualifier.
    always_comb begin
        sync_slot = ~nDSYNC;
        vs_fall   = sync_slot & sync_pre[3] & ~d_cur[3];
        hs_fall   = sync_slot & sync_pre[1] & ~d_cur[1];
        cs_rise   = sync_slot & ~sync_pre[0] & d_cur[0];
        eval      = sync_slot & ~blurry_pixel_pos & ~n64_480i;
    end

    // Gradient direction of the addressed channel and reversal capture per channel.
    always_comb begin
        pre_ch = '0;
        case (data_cnt)
            2'd1:    pre_ch = rgb_pre[3*COLOR_W-1 -: COLOR_W];
            2'd2:    pre_ch = rgb_pre[2*COLOR_W-1 -: COLOR_W];
            2'd3:    pre_ch = rgb_pre[COLOR_W-1:0];
            default: pre_ch = '0;
        endcase
        pre_msb = pre_ch[COLOR_W-1 -: CMP_BITS];
        cur_msb = d_cur[COLOR_W-1 -: CMP_BITS];
        g       = {pre_msb < cur_msb, pre_msb > cur_msb};

        grad_d = grad_q;
        rev_d  = rev_q;
        if (nDSYNC && !n64_480i) begin
            for (int c = 0; c < 3; c++) begin
                if (data_cnt == 2'(c + 1)) begin
                    if (blurry_pixel_pos) begin
                        grad_d[c] = g;
                    end else if ((grad_q[c] ^ g) == 2'b11) begin
                        rev_d[c] = 1'b1;
                    end
                end
            end
        end
        if (eval) begin
            rev_d = '0;
        end
    end

    // Per-frame event counter with holdoff between counted events.
    always_comb begin
        est_cnt_d = est_cnt_q;
        holdoff_d = holdoff_q;
        if (eval) begin
            if (holdoff_q != '0) begin
                holdoff_d = holdoff_q + HOLDOFF_W'(1);
            end
            if (&rev_q) begin
                if (holdoff_q == '0 && est_cnt_q != '1) begin
                    est_cnt_d = est_cnt_q + EST_CNT_W'(1);
                end
                holdoff_d = HOLDOFF_W'(1);
            end
        end
        // Line start re-arms counting; a same-slot count still stands.
        if (hs_fall) begin
            holdoff_d = '0;
        end
        if (vs_fall && !n64_480i) begin
            est_cnt_d = '0;
        end
    end

    // Frame-rate trend, hysteresis decision, lock tracking and output controls.
    always_comb begin
        trend_d     = trend_q;
        nblur_d     = nblur_q;
        ndo_d       = ndo_q;
        nblank_d    = nblank_q;
        run_est_d   = run_est_q;
        frame_cnt_d = frame_cnt_q;

        if (vs_fall && !n64_480i) begin
            // The first frame after (re)start is partial, so it does not move the trend.
            if (run_est_q) begin
                if (est_cnt_q == '1) begin
                    if (trend_q != '1) trend_d = trend_q + TREND_W'(1);
                end else begin
                    if (trend_q != '0) trend_d = trend_q - TREND_W'(1);
                end
                if (frame_cnt_q != LockFrames) frame_cnt_d = frame_cnt_q + 8'd1;
            end
            if (trend_q >= TrendHi) begin
                nblur_d = 1'b1;
            end else if (trend_q <= TrendLo) begin
                nblur_d = 1'b0;
            end
            run_est_d = 1'b1;
        end

        if (n64_480i) begin
            run_est_d   = 1'b0;
            frame_cnt_d = '0;
        end

        if (vs_fall) begin
            if (n64_480i)      ndo_d = 1'b1;
            else if (force_en) ndo_d = force_nval;
            else               ndo_d = nblur_q;
        end

        if (sync_slot) begin
            if (ndo_q)        nblank_d = 1'b1;
            else if (cs_rise) nblank_d = vmode;
            else              nblank_d = ~nblank_q;
        end
    end

    // State registers on the falling pixel-clock edge with synchronous reset.
    always_ff @(negedge nCLK) begin
        if (!nRST) begin
            grad_q      <= '0;
            rev_q       <= '0;
            est_cnt_q   <= '0;
            holdoff_q   <= '0;
            trend_q     <= TrendInit;
            nblur_q     <= 1'b1;
            ndo_q       <= 1'b1;
            nblank_q    <= 1'b1;
            run_est_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            grad_q      <= grad_d;
            rev_q       <= rev_d;
            est_cnt_q   <= est_cnt_d;
            holdoff_q   <= holdoff_d;
            trend_q     <= trend_d;
            nblur_q     <= nblur_d;
            ndo_q       <= ndo_d;
            nblank_q    <= nblank_d;
            run_est_q   <= run_est_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign trend      = trend_q;
    assign nblur_est  = nblur_q;
    assign ndo_deblur = ndo_q;
    assign nblank_rgb = nblank_q;
    assign est_locked = (frame_cnt_q == LockFrames);

endmodule

// File: tb/tb_n64_deblur_est.sv
// Scoreboard bench for n64_deblur_est: a slot-level reference model predicts the outputs
// after every falling edge; a monitor on the rising edge compares them.
module tb_n64_deblur_est;

    localparam int TrInit  = 256;
    localparam int TrHi    = 264;
    localparam int TrLo    = 248;
    localparam int TrMax   = 511;
    localparam int EstMax  = 3;
    localparam int HoldMod = 4;
    localparam int LockN   = 4;

    logic        nCLK = 1'b0;
    logic        nRST = 1'b0;
    logic        nDSYNC = 1'b1;
    logic [1:0]  data_cnt = 2'd0;
    logic        blurry_pixel_pos = 1'b0;
    logic        n64_480i = 1'b0;
    logic        vmode = 1'b0;
    logic [3:0]  sync_pre = 4'hF;
    logic [20:0] rgb_pre = '0;
    logic [6:0]  d_cur = '0;
    logic        force_en = 1'b0;
    logic        force_nval = 1'b1;
    logic        ndo_deblur, nblank_rgb, nblur_est, est_locked;
    logic [8:0]  trend;

    always #5 nCLK = ~nCLK;

    n64_deblur_est dut (
        .nCLK             (nCLK),
        .nRST             (nRST),
        .nDSYNC           (nDSYNC),
        .data_cnt         (data_cnt),
        .blurry_pixel_pos (blurry_pixel_pos),
        .n64_480i         (n64_480i),
        .vmode            (vmode),
        .sync_pre         (sync_pre),
        .rgb_pre          (rgb_pre),
        .d_cur            (d_cur),
        .force_en         (force_en),
        .force_nval       (force_nval),
        .ndo_deblur       (ndo_deblur),
        .nblank_rgb       (nblank_rgb),
        .nblur_est        (nblur_est),
        .trend            (trend),
        .est_locked       (est_locked)
    );

    typedef struct {
        int trend;
        int nblur;
        int ndo;
        int nblank;
        int locked;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state, kept in behavioural terms (directions as signs, counts as ints).
    int m_trend, m_nblur, m_ndo, m_nblank, m_run, m_fc, m_est, m_hold;
    int m_dir[3];
    bit m_rev[3];

    function automatic int sgn(input int v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    task automatic model(input bit rst, input bit nd, input bit [1:0] dc, input bit bp,
                         input bit [3:0] sp, input bit [20:0] rp, input bit [6:0] cur);
        int o_trend, o_nblur, o_ndo, o_est, o_hold, o_run, c, pv, cv, d;
        bit vs, hs, cs, all_rev;
        exp_t e;
        if (!rst) begin
            m_trend = TrInit; m_nblur = 1; m_ndo = 1; m_nblank = 1;
            m_run = 0; m_fc = 0; m_est = 0; m_hold = 0;
            for (int i = 0; i < 3; i++) begin m_dir[i] = 0; m_rev[i] = 0; end
        end else begin
            o_trend = m_trend; o_nblur = m_nblur; o_ndo = m_ndo;
            o_est = m_est; o_hold = m_hold; o_run = m_run;
            all_rev = m_rev[0] && m_rev[1] && m_rev[2];
            if (!nd) begin
                vs = sp[3] && !cur[3];
                hs = sp[1] && !cur[1];
                cs = !sp[0] && cur[0];
                if (!n64_480i && !bp) begin
                    if (o_hold != 0) m_hold = (o_hold + 1) % HoldMod;
                    if (all_rev) begin
                        if (o_hold == 0) m_est = (o_est < EstMax) ? o_est + 1 : EstMax;
                        m_hold = 1;
                    end
                    for (int i = 0; i < 3; i++) m_rev[i] = 0;
                end
                if (hs) m_hold = 0;
                if (vs && !n64_480i) begin
                    if (o_run) begin
                        if (o_est == EstMax) m_trend = (o_trend < TrMax) ? o_trend + 1 : TrMax;
                        else                 m_trend = (o_trend > 0) ? o_trend - 1 : 0;
                        m_fc = (m_fc < LockN) ? m_fc + 1 : LockN;
                    end
                    if (o_trend >= TrHi)      m_nblur = 1;
                    else if (o_trend <= TrLo) m_nblur = 0;
                    m_est = 0;
                    m_run = 1;
                end
                if (vs) m_ndo = n64_480i ? 1 : (force_en ? int'(force_nval) : o_nblur);
                if (o_ndo == 1) m_nblank = 1;
                else if (cs)    m_nblank = int'(vmode);
                else            m_nblank = 1 - m_nblank;
            end else if (!n64_480i && dc != 0) begin
                c  = int'(dc) - 1;
                pv = int'((rp >> (7 * (2 - c) + 5)) & 21'd3);
                cv = int'(cur >> 5);
                d  = sgn(cv - pv);
                if (bp) m_dir[c] = d;
                else if (m_dir[c] * d == -1) m_rev[c] = 1;
            end
            if (n64_480i) begin
                m_run = 0;
                m_fc  = 0;
            end
        end
        e.trend = m_trend; e.nblur = m_nblur; e.ndo = m_ndo; e.nblank = m_nblank;
        e.locked = (m_fc == LockN) ? 1 : 0;
        sb.push_back(e);
    endtask

    // Monitor: outputs settle after the falling edge; compare on the rising edge.
    initial begin
        forever begin
            @(posedge nCLK);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("trend",      int'(trend),      mon_e.trend);
                chk("nblur_est",  int'(nblur_est),  mon_e.nblur);
                chk("ndo_deblur", int'(ndo_deblur), mon_e.ndo);
                chk("nblank_rgb", int'(nblank_rgb), mon_e.nblank);
                chk("est_locked", int'(est_locked), mon_e.locked);
            end
        end
    end

    task automatic slot(input bit rst, input bit nd, input bit [1:0] dc, input bit bp,
                        input bit [3:0] sp, input bit [20:0] rp, input bit [6:0] cur);
        @(posedge nCLK);
        #1;
        nRST = rst; nDSYNC = nd; data_cnt = dc; blurry_pixel_pos = bp;
        sync_pre = sp; rgb_pre = rp; d_cur = cur;
        model(rst, nd, dc, bp, sp, rp, cur);
        @(negedge nCLK);
        #1;
    endtask

    task automatic sync_w(input bit [3:0] sp, input bit [3:0] cur);
        slot(1'b1, 1'b0, 2'd0, 1'b0, sp, '0, {3'b000, cur});
    endtask

    task automatic do_reset();
        slot(1'b0, 1'b1, 2'd0, 1'b0, 4'hF, '0, '0);
        slot(1'b0, 1'b0, 2'd0, 1'b0, 4'hF, '0, 7'h0F);
    endtask

    // vs_fall, plain sync, cs_rise.
    task automatic idle_frame();
        vmode = 1'($urandom);
        sync_w(4'hF, 4'h7);
        sync_w(4'h7, 4'hF);
        sync_w(4'hE, 4'hF);
    endtask

    // All three channels fall on the blurry pixel and rise on its partner.
    task automatic rev_pairs();
        for (int c = 1; c <= 3; c++) slot(1'b1, 1'b1, 2'(c), 1'b1, 4'hF, {3{7'h60}}, 7'h20);
        for (int c = 1; c <= 3; c++) slot(1'b1, 1'b1, 2'(c), 1'b0, 4'hF, {3{7'h20}}, 7'h60);
    endtask

    task automatic rev_line();
        rev_pairs();
        sync_w(4'hF, 4'hF);
        sync_w(4'hF, 4'hD);
    endtask

    task automatic rev_frame();
        for (int l = 0; l < 4; l++) rev_line();
        sync_w(4'hF, 4'h7);
    endtask

    initial begin
        // Reset state and idle frames.
        do_reset();
        chk("reset_trend", int'(trend), 256);
        chk("reset_ndo", int'(ndo_deblur), 1);
        for (int f = 0; f < 3; f++) idle_frame();
        chk("idle3_trend", int'(trend), 254);
        chk("idle3_locked", int'(est_locked), 0);
        for (int f = 0; f < 2; f++) idle_frame();
        chk("idle5_locked", int'(est_locked), 1);
        chk("idle5_trend", int'(trend), 252);

        // Sharp frames climb the trend.
        do_reset();
        for (int f = 0; f < 9; f++) rev_frame();
        chk("sharp_trend", int'(trend), 264);
        chk("sharp_nblur", int'(nblur_est), 1);

        // Forced de-blur takes effect only at the next vs_fall.
        force_en = 1'b1; force_nval = 1'b0;
        sync_w(4'hF, 4'hF);
        sync_w(4'hE, 4'hF);
        chk("force_pre_vs_ndo", int'(ndo_deblur), 1);
        sync_w(4'hF, 4'h7);
        chk("force_ndo", int'(ndo_deblur), 0);
        for (int i = 0; i < 6; i++) begin
            vmode = 1'($urandom);
            sync_w(((i % 3) == 0) ? 4'hE : 4'hF, 4'hF);
        end
        n64_480i = 1'b1;
        sync_w(4'hF, 4'h7);
        sync_w(4'hF, 4'hF);
        chk("i480_ndo", int'(ndo_deblur), 1);
        chk("i480_nblank", int'(nblank_rgb), 1);
        chk("i480_locked", int'(est_locked), 0);
        chk("i480_trend", int'(trend), 263);
        rev_line();
        n64_480i = 1'b0; force_en = 1'b0; force_nval = 1'b1;

        // Same-slot corner cases.
        do_reset();
        for (int f = 0; f < 3; f++) begin
            rev_pairs(); sync_w(4'hF, 4'hD);
            rev_pairs(); sync_w(4'hF, 4'hF);
            rev_pairs(); sync_w(4'hF, 4'hF);
            rev_pairs(); sync_w(4'hF, 4'h7);
        end

        // Long idle run: trend saturates at zero, de-blur engages.
        do_reset();
        for (int f = 0; f < 300; f++) idle_frame();
        chk("idle300_trend", int'(trend), 0);
        chk("idle300_nblur", int'(nblur_est), 0);
        chk("idle300_ndo", int'(ndo_deblur), 0);

        // Mid-frame reset from trend 300 with de-blur forced on.
        do_reset();
        for (int f = 0; f < 44; f++) rev_frame();
        force_en = 1'b1; force_nval = 1'b0;
        rev_frame();
        chk("pre_rst_trend", int'(trend), 300);
        chk("pre_rst_ndo", int'(ndo_deblur), 0);
        chk("pre_rst_locked", int'(est_locked), 1);
        rev_pairs();
        slot(1'b0, 1'b1, 2'd2, 1'b0, 4'hF, {3{7'h20}}, 7'h60);
        chk("rst_trend", int'(trend), 256);
        chk("rst_ndo", int'(ndo_deblur), 1);
        chk("rst_nblank", int'(nblank_rgb), 1);
        chk("rst_locked", int'(est_locked), 0);
        force_en = 1'b0;

        // Randomised slots.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) n64_480i = ~n64_480i;
            if ($urandom_range(0, 99) == 0) force_en = ~force_en;
            force_nval = 1'($urandom);
            vmode      = 1'($urandom);
            slot(($urandom_range(0, 299) != 0), 1'($urandom), 2'($urandom), 1'($urandom),
                 4'($urandom), 21'($urandom), 7'($urandom));
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge nCLK);
        #1;
        if (sb.size() != 0) chk("scoreboard_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
